// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for branch resolution.
// Holds the branch operation enum, the resolver state enum, the delay-slot
// link offset and small decode helpers used by the top and the target unit.
package branch_resolve_pkg;

    typedef enum logic [4:0] {
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
        OP_BEQL, OP_BNEL, OP_BLEZL, OP_BGTZL, OP_BLTZL, OP_BGEZL, OP_BLTZALL, OP_BGEZALL,
        OP_J, OP_JAL, OP_JR, OP_JALR
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SLOT,
        REDIRECT
    } br_state_e;

    // Return address skips the branch and its delay slot.
    localparam logic [31:0] DS_OFFSET = 32'd8;

    function automatic logic is_likely(input br_op_e op);
        return (op >= OP_BEQL) && (op <= OP_BGEZALL);
    endfunction

    function automatic logic is_link(input br_op_e op);
        return (op == OP_BLTZAL) || (op == OP_BGEZAL) || (op == OP_BLTZALL) ||
               (op == OP_BGEZALL) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_resolve_target.sv
// Combinational target and link address computation.
// Ports:
//   i_br_op        branch operation code
//   i_pc_id        address of the branch instruction
//   i_target_field instr_index; [15:0] is the PC-relative offset
//   i_rs_data      register target for JR/JALR
//   o_target       resolved branch/jump target
//   o_link_addr    return address (branch + 8)
module branch_target
    import branch_resolve_pkg::*;
(
    input  logic [4:0]  i_br_op,
    input  logic [31:0] i_pc_id,
    input  logic [25:0] i_target_field,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_target,
    output logic [31:0] o_link_addr
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_offset;
    logic [31:0] w_rel;
    logic [31:0] w_abs;

    assign w_pc_plus4 = i_pc_id + 32'd4;
    assign w_offset   = {{14{i_target_field[15]}}, i_target_field[15:0], 2'b00};
    assign w_rel      = w_pc_plus4 + w_offset;
    // Region-absolute jump keeps the top nibble of the delay-slot address.
    assign w_abs      = {w_pc_plus4[31:28], i_target_field, 2'b00};

    always_comb begin
        o_target = w_rel;
        case (br_op_e'(i_br_op))
            OP_J, OP_JAL:   o_target = w_abs;
            OP_JR, OP_JALR: o_target = i_rs_data;
            default:        o_target = w_rel;
        endcase
    end

    assign o_link_addr = i_pc_id + DS_OFFSET;

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution controller for a single-delay-slot pipeline.
// Accepts a branch in ID, tracks the delay slot, then issues a redirect to
// fetch for taken branches. Likely branches that fall through squash the slot.
// Ports:
//   i_clock, i_reset                   clock, synchronous active-high reset
//   i_br_valid, i_br_op                branch present in ID and its opcode
//   i_pc_id, i_target_field, i_rs_data target inputs
//   i_eq/gz/lz/gez/lez                 condition flags
//   i_stall, i_flush                   ID stall, exception flush
//   i_ds_advance                       delay-slot instruction leaves ID
//   i_redirect_ack                     fetch took the redirect
//   o_redirect_valid/o_redirect_pc     redirect request to fetch
//   o_nullify_ds, o_in_delay_slot      delay-slot status
//   o_link_valid/o_link_addr           link write pulse and value
//   o_br_err                           branch seen in a delay slot
//
// state    | meaning
// IDLE     | no branch outstanding, ready to accept
// SLOT     | branch accepted, delay-slot instruction in ID
// REDIRECT | taken branch waiting for fetch to accept target
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_br_valid,
    input  logic [4:0]  i_br_op,
    input  logic [31:0] i_pc_id,
    input  logic [25:0] i_target_field,
    input  logic [31:0] i_rs_data,
    input  logic        i_eq,
    input  logic        i_gz,
    input  logic        i_lz,
    input  logic        i_gez,
    input  logic        i_lez,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_ds_advance,
    input  logic        i_redirect_ack,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_nullify_ds,
    output logic        o_in_delay_slot,
    output logic        o_link_valid,
    output logic [31:0] o_link_addr,
    output logic        o_br_err
);

    br_state_e   r_state;
    logic        r_taken;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        r_nullify_ds;
    logic        r_in_delay_slot;
    logic        r_link_valid;
    logic [31:0] r_link_addr;
    logic        r_br_err;

    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_link_addr;

    branch_target u_target (
        .i_br_op        (i_br_op),
        .i_pc_id        (i_pc_id),
        .i_target_field (i_target_field),
        .i_rs_data      (i_rs_data),
        .o_target       (w_target),
        .o_link_addr    (w_link_addr)
    );

    always_comb begin
        w_taken = 1'b0;
        case (br_op_e'(i_br_op))
            OP_BEQ,    OP_BEQL:                         w_taken = i_eq;
            OP_BNE,    OP_BNEL:                         w_taken = ~i_eq;
            OP_BLEZ,   OP_BLEZL:                        w_taken = i_lez;
            OP_BGTZ,   OP_BGTZL:                        w_taken = i_gz;
            OP_BLTZ,   OP_BLTZL, OP_BLTZAL, OP_BLTZALL: w_taken = i_lz;
            OP_BGEZ,   OP_BGEZL, OP_BGEZAL, OP_BGEZALL: w_taken = i_gez;
            OP_J, OP_JAL, OP_JR, OP_JALR:               w_taken = 1'b1;
            default:                                    w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_taken          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'h0;
            r_nullify_ds     <= 1'b0;
            r_in_delay_slot  <= 1'b0;
            r_link_valid     <= 1'b0;
            r_link_addr      <= 32'h0;
            r_br_err         <= 1'b0;
        end else begin
            // Link and error are single-cycle pulses.
            r_link_valid <= 1'b0;
            r_br_err     <= 1'b0;
            if (i_flush) begin
                r_state          <= IDLE;
                r_redirect_valid <= 1'b0;
                r_nullify_ds     <= 1'b0;
                r_in_delay_slot  <= 1'b0;
            end else if (!i_stall) begin
                case (r_state)
                    IDLE: begin
                        if (i_br_valid) begin
                            r_state         <= SLOT;
                            r_taken         <= w_taken;
                            r_redirect_pc   <= w_target;
                            r_in_delay_slot <= 1'b1;
                            r_nullify_ds    <= is_likely(br_op_e'(i_br_op)) & ~w_taken;
                            if (is_link(br_op_e'(i_br_op))) begin
                                r_link_valid <= 1'b1;
                                r_link_addr  <= w_link_addr;
                            end
                        end
                    end
                    SLOT: begin
                        if (i_br_valid) r_br_err <= 1'b1;
                        if (i_ds_advance) begin
                            r_in_delay_slot <= 1'b0;
                            r_nullify_ds    <= 1'b0;
                            if (r_taken) begin
                                r_state          <= REDIRECT;
                                r_redirect_valid <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    REDIRECT: begin
                        if (i_br_valid) r_br_err <= 1'b1;
                        if (i_redirect_ack) begin
                            r_state          <= IDLE;
                            r_redirect_valid <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_nullify_ds     = r_nullify_ds;
    assign o_in_delay_slot  = r_in_delay_slot;
    assign o_link_valid     = r_link_valid;
    assign o_link_addr      = r_link_addr;
    assign o_br_err         = r_br_err;

endmodule
